// File: rtl/mem_access.sv
// mem_access: TinyRisc-V memory stage; req/ack data bus, lane formatting, one registered result per instruction.
// Optional MISALIGN_TRAP_EN traps misaligned half/word accesses instead of silently aligning them down.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr,
    input  logic        reg_write,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        misalign_trap
);
    typedef enum logic {IDLE, BUS} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_lane, r_size;
    logic        r_uns, r_rw;
    logic [4:0]  r_rd;
    logic        w_mem, w_mis, w_half, w_word, w_ack, w_stall, w_ext;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_hword;
    logic [31:0] w_wdata, w_load;

    assign w_lane = alu_out[1:0];
    assign w_mem  = valid_in & (mem_read | mem_write);
    assign w_half = mem_size == 2'd1;
    assign w_word = mem_size[1];
`ifdef MISALIGN_TRAP_EN
    assign w_mis  = w_mem & ((w_half & w_lane[0]) | (w_word & (|w_lane)));
`else
    assign w_mis  = 1'b0;
`endif
    // An ack only counts while a request is actually outstanding
    assign w_ack  = dmem_ack & dmem_req;

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        if (r_state == IDLE) begin
            w_stall = w_mem & ~w_mis;
            w_next  = (w_mem & ~w_mis) ? BUS : IDLE;
        end else begin
            w_stall = ~w_ack;
            w_next  = w_ack ? IDLE : BUS;
        end
    end

    assign stall = w_stall & ~rst;

    assign w_wdata = (mem_size == 2'd0) ? {4{rs2_data[7:0]}} :
                     w_half             ? {2{rs2_data[15:0]}} : rs2_data;
    assign w_be    = (mem_size == 2'd0) ? (4'b0001 << w_lane) :
                     w_half             ? (4'b0011 << {w_lane[1], 1'b0}) : 4'b1111;

    assign w_byte  = dmem_rdata[{r_lane, 3'b000} +: 8];
    assign w_hword = dmem_rdata[{r_lane[1], 4'b0000} +: 16];
    assign w_ext   = ~r_uns & ((r_size == 2'd0) ? w_byte[7] : w_hword[15]);
    assign w_load  = (r_size == 2'd0) ? {{24{w_ext}}, w_byte} :
                     (r_size == 2'd1) ? {{16{w_ext}}, w_hword} : dmem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            misalign_trap <= 1'b0;
            r_lane        <= '0;
            r_size        <= '0;
            r_uns         <= 1'b0;
            r_rw          <= 1'b0;
            r_rd          <= '0;
        end else begin
            wb_valid      <= 1'b0;
            misalign_trap <= 1'b0;
            if (r_state == IDLE) begin
                if (w_mis) begin
                    wb_valid      <= 1'b1;
                    misalign_trap <= 1'b1;
                    wb_rd         <= rd_addr;
                    wb_reg_write  <= 1'b0;
                    wb_data       <= alu_out;
                end else if (w_mem) begin
                    // Store wins when both read and write are requested
                    dmem_req   <= 1'b1;
                    dmem_we    <= mem_write;
                    dmem_addr  <= {alu_out[31:2], 2'b00};
                    dmem_wdata <= w_wdata;
                    dmem_be    <= w_be;
                    r_lane     <= w_lane;
                    r_size     <= mem_size;
                    r_uns      <= mem_unsigned;
                    r_rd       <= rd_addr;
                    r_rw       <= reg_write & ~mem_write;
                end else if (valid_in) begin
                    wb_valid     <= 1'b1;
                    wb_rd        <= rd_addr;
                    wb_reg_write <= reg_write;
                    wb_data      <= alu_out;
                end
            end else if (w_ack) begin
                dmem_req     <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= r_rd;
                wb_reg_write <= r_rw;
                wb_data      <= dmem_we ? 32'd0 : w_load;
            end
        end
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the TinyRisc-V core, directly downstream of `execute`. It takes the ALU result (`alu_out`) as an effective address or pass-through value, runs load/store transactions on the data-memory bus with a req/ack handshake, and formats the data. It presents one registered result per instruction to writeback and stalls upstream while a bus access is outstanding.

## Interface
- Parameters: none.
- `clk`  in  1  — single clock; all state on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `valid_in`  in  1  — instruction present on the inputs this cycle.
- `mem_read`  in  1  — load.
- `mem_write`  in  1  — store.
- `mem_size`  in  2  — 0 byte, 1 half, 2 word, 3 treated as word.
- `mem_unsigned`  in  1  — zero-extend loads (LBU/LHU).
- `alu_out`  in  32  — effective address, or the result for non-memory instructions.
- `rs2_data`  in  32  — store data.
- `rd_addr`  in  5  — destination register.
- `reg_write`  in  1  — instruction writes `rd`.
- `stall`  out  1  — upstream must hold all inputs stable while high.
- `dmem_req`  out  1  — bus request (registered).
- `dmem_we`  out  1  — write request.
- `dmem_addr`  out  32  — word-aligned address, `{alu_out[31:2],2'b00}`.
- `dmem_wdata`  out  32  — lane-replicated store data.
- `dmem_be`  out  4  — byte enables.
- `dmem_ack`  in  1  — transaction complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata`  in  32  — read word.
- `wb_valid`  out  1  — one-cycle result pulse to writeback.
- `wb_rd`  out  5  — destination register.
- `wb_reg_write`  out  1  — write enable to the register file.
- `wb_data`  out  32  — load data or the `alu_out` pass-through.
- `misalign_trap`  out  1  — misaligned access (see Configuration).

## Operation
- FSM states: IDLE, BUS.
- IDLE, `valid_in` with neither `mem_read` nor `mem_write`:
  - Next cycle: `wb_valid`=1, `wb_data`=`alu_out`, `wb_rd`/`wb_reg_write` from the inputs.
  - `stall`=0.
- IDLE, `valid_in` with `mem_read` or `mem_write`:
  - Latch address, size, sign, `we`, `wdata`, `be`, `rd`, `reg_write`; go to BUS. `stall`=1.
  - If both `mem_read` and `mem_write` are set, the store wins.
- BUS:
  - `dmem_req`=1, and all `dmem_*` outputs are held constant.
  - `stall`=1 while `dmem_ack`=0.
  - On `dmem_ack`: `stall`=0 in that cycle, so the inputs count as consumed. Go to IDLE.
  - Next cycle: `wb_valid`=1. `dmem_req` drops the cycle after the ack.
- Load formatting, lane = `alu_out[1:0]`:
  - Byte: `rdata[8*lane+:8]`.
  - Half: `rdata[16*lane[1]+:16]`.
  - Word: `rdata`.
  - Sign-extend unless `mem_unsigned`.
- Store formatting:
  - Byte: `wdata={4{rs2[7:0]}}`, `be=4'b0001<<lane`.
  - Half: `wdata={2{rs2[15:0]}}`, `be=4'b0011<<(2*lane[1])`.
  - Word: `be=4'b1111`.
- Stores: `wb_valid`=1, `wb_reg_write`=0, `wb_data`=0.
- Loads with `rd_addr`=0: `wb_reg_write` is passed through unchanged; x0 is suppressed in the register file.
- `dmem_ack` is ignored while `dmem_req`=0.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be`, `wb_valid`, `wb_rd`, `wb_reg_write`, `wb_data`, `misalign_trap` all 0.
- `stall` is 0 in reset and is combinational from state and inputs.
- Non-memory latency: 1 cycle from input to `wb_valid`.
- Memory latency: input at cycle 0, `dmem_req` at cycle 1, ack at cycle k≥1, `wb_valid` at cycle k+1.
- Minimum memory latency is 2 cycles (ack in the first request cycle).
- `wb_valid` is exactly one cycle per accepted instruction. Back-to-back non-memory instructions give a pulse every cycle.
- A new instruction may be presented in the cycle after an ack and is accepted while the previous `wb_valid` is high.
- Reset mid-transaction forces IDLE immediately. A late `dmem_ack` is then ignored, and no `wb_valid` is produced for the aborted instruction.

## Configuration
- Macro: `MISALIGN_TRAP_EN`.
- Defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, issues no bus request; `stall`=0.
  - Next cycle: `wb_valid`=1, `misalign_trap`=1 (one cycle), `wb_reg_write`=0, `wb_data`=faulting address.
- Undefined:
  - `misalign_trap` is tied 0.
  - Half accesses use `lane[1]` only; word accesses ignore `lane`. The access is silently aligned down.

## Test plan
- ADD pass-through: `valid_in`=1, `alu_out`=0x105, `rd`=3, `reg_write`=1 → next cycle `wb_valid`=1, `wb_data`=0x105, `stall`=0, no `dmem_req`.
- LB at 0x102, rdata=0x12F03456, ack after 3 wait cycles → `stall` high 3 cycles, `dmem_addr`=0x100, `wb_data`=0xFFFFFFF0. Same with LBU → 0x000000F0.
- SH at 0x106 of `rs2`=0xABCD1234, immediate ack → `dmem_we`=1, `be`=4'b1100, `wdata`=0x12341234, `wb_reg_write`=0.
- SW then LW back-to-back at 0x200 → two bus transactions, two `wb_valid` pulses, load returns the stored word from the bus model.
- `rst` pulse during BUS with ack pending → `dmem_req`=0 immediately, later ack ignored, no `wb_valid`.
- LW at 0x103: with `MISALIGN_TRAP_EN`, `misalign_trap`=1, `wb_data`=0x103, no `dmem_req`. Without it, `dmem_addr`=0x100 and a normal load.
